// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: reset/instruction-memory window defaults,
// NOP encoding, next-PC opcode encodings and the fetch-address legality check.
package fetch_stage_pkg;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
  localparam logic [31:0] IM_END_DEF   = 32'h0000_6FFF;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  // Next-PC unit opcodes, kept here so every stage agrees on the encoding
  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_JR     = 2'd3
  } npc_op_e;

  // A fetch is illegal when misaligned or outside [lo, hi]
  function automatic logic fetch_illegal(input logic [31:0] pc,
                                         input logic [31:0] lo,
                                         input logic [31:0] hi);
    return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
  endfunction

endpackage

// File: rtl/f_d_reg.sv
// Fetch/decode pipeline register. clr inserts a bubble and wins over en;
// with en low and clr low every field holds.
module f_d_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RST_PC = PC_RESET_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic        in_valid,
  input  logic        in_exc,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_valid,
  output logic        out_exc
);

  // Capture, bubble, or hold the F/D entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_pc    <= RST_PC;
      out_instr <= NOP;
      out_valid <= 1'b0;
      out_exc   <= 1'b0;
    end else if (clr) begin
      out_pc    <= in_pc;
      out_instr <= NOP;
      out_valid <= 1'b0;
      out_exc   <= 1'b0;
    end else if (en) begin
      out_pc    <= in_pc;
      out_instr <= in_instr;
      out_valid <= in_valid;
      out_exc   <= in_exc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, fetch-address check, F/D register
// and a count of instructions accepted into F/D.
// Control semantics: stall freezes PC and F/D; flush turns the next F/D
// capture into a bubble even while stalled (PC still obeys stall).
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter logic [31:0] IM_END   = IM_END_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] npc,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] i_inst_addr,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_Instr,
  output logic        D_Valid,
  output logic        D_ExcAdEL,
  output logic [31:0] F_Count
);

  logic [31:0] pc;
  logic [31:0] f_count;
  logic        illegal;
  logic [31:0] fetch_instr;
  logic        valid_capture;

  assign i_inst_addr   = pc;
  assign F_PC          = pc;
  assign illegal       = fetch_illegal(pc, IM_BASE, IM_END);
  // Illegal fetches never forward whatever memory returned
  assign fetch_instr   = illegal ? NOP : i_inst_rdata;
  assign valid_capture = !stall && !flush;
  assign F_Count       = f_count;

  // PC follows npc unless stalled; npc is not range-checked here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= PC_RESET;
    else if (!stall) pc <= npc;
  end

  // Count instructions that actually enter F/D as valid (wraps naturally)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) f_count <= 32'd0;
    else if (valid_capture) f_count <= f_count + 32'd1;
  end

  f_d_reg #(.RST_PC(PC_RESET)) u_f_d_reg (
    .clk      (clk),
    .reset    (reset),
    .en       (!stall),
    .clr      (flush),
    .in_pc    (pc),
    .in_instr (fetch_instr),
    .in_valid (1'b1),
    .in_exc   (illegal),
    .out_pc   (D_PC),
    .out_instr(D_Instr),
    .out_valid(D_Valid),
    .out_exc  (D_ExcAdEL)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction memory model.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] npc;
  logic [31:0] i_inst_rdata;
  logic [31:0] i_inst_addr;
  logic [31:0] F_PC;
  logic [31:0] D_PC;
  logic [31:0] D_Instr;
  logic        D_Valid;
  logic        D_ExcAdEL;
  logic [31:0] F_Count;

  logic        use_ovr;
  logic [31:0] ovr_pc;
  int          total;
  int          bad;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .npc         (npc),
    .i_inst_rdata(i_inst_rdata),
    .i_inst_addr (i_inst_addr),
    .F_PC        (F_PC),
    .D_PC        (D_PC),
    .D_Instr     (D_Instr),
    .D_Valid     (D_Valid),
    .D_ExcAdEL   (D_ExcAdEL),
    .F_Count     (F_Count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory model: one fixed word, otherwise a tagged address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h3C01_0001;
    return {16'h1234, a[15:0]};
  endfunction

  assign i_inst_rdata = mem_word(i_inst_addr);
  assign npc = use_ovr ? ovr_pc : F_PC + 32'd4;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; use_ovr = 1'b0; ovr_pc = 32'h0;
    #3;
    total++; if (F_PC !== 32'h3000) begin bad++; $display("FAIL reset_fpc got %h want %h", F_PC, 32'h3000); end
    total++; if (D_PC !== 32'h3000) begin bad++; $display("FAIL reset_dpc got %h want %h", D_PC, 32'h3000); end
    total++; if (D_Instr !== 32'h0) begin bad++; $display("FAIL reset_instr got %h want 0", D_Instr); end
    total++; if (D_Valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", D_Valid); end
    total++; if (D_ExcAdEL !== 1'b0) begin bad++; $display("FAIL reset_exc got %b want 0", D_ExcAdEL); end
    total++; if (F_Count !== 32'h0) begin bad++; $display("FAIL reset_count got %h want 0", F_Count); end
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    step();
    total++; if (D_PC !== 32'h3000) begin bad++; $display("FAIL fetch1_dpc got %h want %h", D_PC, 32'h3000); end
    total++; if (D_Instr !== 32'h3C01_0001) begin bad++; $display("FAIL fetch1_instr got %h want %h", D_Instr, 32'h3C01_0001); end
    total++; if (D_Valid !== 1'b1) begin bad++; $display("FAIL fetch1_valid got %b want 1", D_Valid); end
    total++; if (F_Count !== 32'd1) begin bad++; $display("FAIL fetch1_count got %0d want 1", F_Count); end
    total++; if (i_inst_addr !== 32'h3004) begin bad++; $display("FAIL fetch1_addr got %h want %h", i_inst_addr, 32'h3004); end
    step();
    total++; if (D_PC !== 32'h3004) begin bad++; $display("FAIL fetch2_dpc got %h want %h", D_PC, 32'h3004); end
    total++; if (D_Instr !== 32'h1234_3004) begin bad++; $display("FAIL fetch2_instr got %h want %h", D_Instr, 32'h1234_3004); end
    total++; if (F_Count !== 32'd2) begin bad++; $display("FAIL fetch2_count got %0d want 2", F_Count); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (F_PC !== 32'h3008) begin bad++; $display("FAIL stall_fpc got %h want %h", F_PC, 32'h3008); end
      total++; if (D_PC !== 32'h3004 || D_Instr !== 32'h1234_3004 || D_Valid !== 1'b1)
        begin bad++; $display("FAIL stall_hold got %h/%h/%b want 00003004/12343004/1", D_PC, D_Instr, D_Valid); end
      total++; if (F_Count !== 32'd2) begin bad++; $display("FAIL stall_count got %0d want 2", F_Count); end
    end
    stall = 1'b0;
    step();
    total++; if (D_PC !== 32'h3008) begin bad++; $display("FAIL unstall_dpc got %h want %h", D_PC, 32'h3008); end
    total++; if (F_Count !== 32'd3) begin bad++; $display("FAIL unstall_count got %0d want 3", F_Count); end
  endtask

  task automatic test_flush_stall();
    stall = 1'b1; flush = 1'b1;
    step();
    total++; if (D_Instr !== 32'h0) begin bad++; $display("FAIL flush_instr got %h want 0", D_Instr); end
    total++; if (D_Valid !== 1'b0) begin bad++; $display("FAIL flush_valid got %b want 0", D_Valid); end
    total++; if (D_ExcAdEL !== 1'b0) begin bad++; $display("FAIL flush_exc got %b want 0", D_ExcAdEL); end
    total++; if (D_PC !== 32'h300C) begin bad++; $display("FAIL flush_dpc got %h want %h", D_PC, 32'h300C); end
    total++; if (F_PC !== 32'h300C) begin bad++; $display("FAIL flush_fpc got %h want %h", F_PC, 32'h300C); end
    total++; if (F_Count !== 32'd3) begin bad++; $display("FAIL flush_count got %0d want 3", F_Count); end
    stall = 1'b0; flush = 1'b0;
    step();
    total++; if (D_PC !== 32'h300C || D_Valid !== 1'b1) begin bad++; $display("FAIL postflush got %h/%b want 0000300c/1", D_PC, D_Valid); end
    total++; if (F_Count !== 32'd4) begin bad++; $display("FAIL postflush_count got %0d want 4", F_Count); end
  endtask

  task automatic test_async_reset();
    // PC is now 0x3010; hold it, then reset between edges
    stall = 1'b1;
    step();
    total++; if (F_PC !== 32'h3010) begin bad++; $display("FAIL pre_areset_fpc got %h want %h", F_PC, 32'h3010); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (F_PC !== 32'h3000) begin bad++; $display("FAIL areset_fpc got %h want %h", F_PC, 32'h3000); end
    total++; if (D_PC !== 32'h3000 || D_Instr !== 32'h0 || D_Valid !== 1'b0 || D_ExcAdEL !== 1'b0)
      begin bad++; $display("FAIL areset_fd got %h/%h/%b/%b want 00003000/00000000/0/0", D_PC, D_Instr, D_Valid, D_ExcAdEL); end
    total++; if (F_Count !== 32'h0) begin bad++; $display("FAIL areset_count got %h want 0", F_Count); end
    step();
    reset = 1'b0; stall = 1'b0;
    step();
    total++; if (D_PC !== 32'h3000 || D_Instr !== 32'h3C01_0001) begin bad++; $display("FAIL rerun_fd got %h/%h want 00003000/3c010001", D_PC, D_Instr); end
    total++; if (F_Count !== 32'd1) begin bad++; $display("FAIL rerun_count got %0d want 1", F_Count); end
  endtask

  task automatic test_illegal();
    // PC is 0x3004 here
    use_ovr = 1'b1;
    ovr_pc = 32'h3002; step();   // F/D <- 0x3004
    ovr_pc = 32'h7000; step();   // F/D <- 0x3002
    total++; if (D_PC !== 32'h3002 || D_ExcAdEL !== 1'b1 || D_Instr !== 32'h0 || D_Valid !== 1'b1)
      begin bad++; $display("FAIL misalign got %h/%b/%h/%b want 00003002/1/00000000/1", D_PC, D_ExcAdEL, D_Instr, D_Valid); end
    ovr_pc = 32'h6FFC; step();   // F/D <- 0x7000
    total++; if (D_PC !== 32'h7000 || D_ExcAdEL !== 1'b1 || D_Instr !== 32'h0 || D_Valid !== 1'b1)
      begin bad++; $display("FAIL above_end got %h/%b/%h/%b want 00007000/1/00000000/1", D_PC, D_ExcAdEL, D_Instr, D_Valid); end
    ovr_pc = 32'h2FFC; step();   // F/D <- 0x6FFC
    total++; if (D_ExcAdEL !== 1'b0 || D_Instr !== 32'h1234_6FFC)
      begin bad++; $display("FAIL last_word got %b/%h want 0/12346ffc", D_ExcAdEL, D_Instr); end
    ovr_pc = 32'h3000; step();   // F/D <- 0x2FFC
    total++; if (D_PC !== 32'h2FFC || D_ExcAdEL !== 1'b1 || D_Instr !== 32'h0)
      begin bad++; $display("FAIL below_base got %h/%b/%h want 00002ffc/1/00000000", D_PC, D_ExcAdEL, D_Instr); end
    total++; if (F_Count !== 32'd6) begin bad++; $display("FAIL illegal_count got %0d want 6", F_Count); end
    use_ovr = 1'b0;
  endtask

  task automatic test_flush_only();
    flush = 1'b1;
    step();
    total++; if (D_Valid !== 1'b0 || F_Count !== 32'd6) begin bad++; $display("FAIL flush_only got %b/%0d want 0/6", D_Valid, F_Count); end
    total++; if (F_PC !== 32'h3004) begin bad++; $display("FAIL flush_only_fpc got %h want %h", F_PC, 32'h3004); end
    flush = 1'b0;
  endtask

  task automatic test_count_wrap();
    force dut.f_count = 32'hFFFF_FFFF;
    #1;
    release dut.f_count;
    total++; if (F_Count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL preload got %h want ffffffff", F_Count); end
    step();
    total++; if (F_Count !== 32'h0) begin bad++; $display("FAIL wrap got %h want 0", F_Count); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_fetch();
    test_stall();
    test_flush_stall();
    test_async_reset();
    test_illegal();
    test_flush_only();
    test_count_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
